// File: rtl/mac_result_drain.sv
// mac_result_drain
//   Unpacks one 56-bit packed accumulator word into 1, 2 or 4 signed lanes
//   and streams them out one lane per cycle. Each lane is sign-extended to
//   56 bits on the way out.
//
//   Ports
//     clk, rst              rising-edge clock; asynchronous active-high reset
//     in_valid/in_ready     input handshake for the packed word
//     in_data[55:0]         packed word, lane 0 in the LSBs
//     in_level[1:0]         00: 1x56b, 01: 2x28b, 10: 4x14b, 11: reserved
//     out_valid/out_ready   output handshake, one lane per beat
//     out_data[55:0]        current lane, sign-extended
//     out_lane[1:0]         index of the current lane
//     out_last              current lane is the final lane of the word
//     out_sat               current lane was clamped
//     err_level             sticky: a reserved level word was received
//
//   Build option
//     MAC_DRAIN_SAT_EN  clamp each lane to signed 16-bit and flag out_sat;
//                       when undefined lanes pass unclamped, out_sat = 0.
module mac_result_drain (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [55:0] in_data,
  input  logic [1:0]  in_level,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [55:0] out_data,
  output logic [1:0]  out_lane,
  output logic        out_last,
  output logic        out_sat,
  output logic        err_level
);

  typedef enum logic {
    IDLE,
    DRAIN
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  lane_cnt_q, lane_cnt_d;
  logic [55:0] data_q, data_d;
  logic [1:0]  level_q, level_d;
  logic        err_q, err_d;

  logic [55:0] lane_raw;
  logic [55:0] lane_val;
  logic        lane_sat;
  logic [1:0]  last_idx;
  logic [27:0] lane28;
  logic [13:0] lane14;
  logic        is_last;
  logic        take;

  // Lane select and sign extension from the captured word.
  always_comb begin
    lane28   = '0;
    lane14   = '0;
    lane_raw = data_q;
    last_idx = 2'd0;
    case (level_q)
      2'b01: begin
        lane28   = lane_cnt_q[0] ? data_q[55:28] : data_q[27:0];
        lane_raw = {{28{lane28[27]}}, lane28};
        last_idx = 2'd1;
      end
      2'b10: begin
        case (lane_cnt_q)
          2'd0:    lane14 = data_q[13:0];
          2'd1:    lane14 = data_q[27:14];
          2'd2:    lane14 = data_q[41:28];
          default: lane14 = data_q[55:42];
        endcase
        lane_raw = {{42{lane14[13]}}, lane14};
        last_idx = 2'd3;
      end
      default: begin
        lane_raw = data_q;
        last_idx = 2'd0;
      end
    endcase
  end

`ifdef MAC_DRAIN_SAT_EN
  always_comb begin
    lane_val = lane_raw;
    lane_sat = 1'b0;
    if ($signed(lane_raw) > $signed(56'sd32767)) begin
      lane_val = 56'sd32767;
      lane_sat = 1'b1;
    end else if ($signed(lane_raw) < -$signed(56'sd32768)) begin
      lane_val = -56'sd32768;
      lane_sat = 1'b1;
    end
  end
`else
  always_comb begin
    lane_val = lane_raw;
    lane_sat = 1'b0;
  end
`endif

  // Outputs are pure functions of registered state, so the asynchronous
  // reset of the state register also forces every output immediately.
  always_comb begin
    is_last   = (state_q == DRAIN) && (lane_cnt_q == last_idx);
    out_valid = (state_q == DRAIN);
    out_data  = (state_q == DRAIN) ? lane_val : '0;
    out_lane  = (state_q == DRAIN) ? lane_cnt_q : '0;
    out_last  = is_last;
    out_sat   = (state_q == DRAIN) && lane_sat;
    err_level = err_q;
    // Accepting on the last beat lets the next word follow without a bubble.
    in_ready  = (state_q == IDLE) || (out_ready && is_last);
    take      = in_valid && in_ready;
  end

  always_comb begin
    state_d    = state_q;
    lane_cnt_d = lane_cnt_q;
    data_d     = data_q;
    level_d    = level_q;
    err_d      = err_q;

    if (state_q == DRAIN && out_ready) begin
      if (is_last) begin
        state_d    = IDLE;
        lane_cnt_d = '0;
      end else begin
        lane_cnt_d = lane_cnt_q + 2'd1;
      end
    end

    if (take) begin
      if (in_level == 2'b11) begin
        err_d = 1'b1;
      end else begin
        data_d     = in_data;
        level_d    = in_level;
        lane_cnt_d = '0;
        state_d    = DRAIN;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      lane_cnt_q <= '0;
      data_q     <= '0;
      level_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      lane_cnt_q <= lane_cnt_d;
      data_q     <= data_d;
      level_q    <= level_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_mac_result_drain.sv
module tb_mac_result_drain;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [55:0] in_data;
  logic [1:0]  in_level;
  logic        out_valid;
  logic        out_ready;
  logic [55:0] out_data;
  logic [1:0]  out_lane;
  logic        out_last;
  logic        out_sat;
  logic        err_level;

  always #5 clk = ~clk;

  mac_result_drain dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_level  (in_level),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_lane  (out_lane),
    .out_last  (out_last),
    .out_sat   (out_sat),
    .err_level (err_level)
  );

  typedef struct {
    logic [1:0]  level;
    logic [55:0] data;
    int          nb;
    longint      l0, l1, l2, l3;
  } vec_t;

  typedef struct {
    logic [55:0] data;
    logic [1:0]  lane;
    logic        last;
    logic        sat;
  } beat_t;

  vec_t  vecs[8];
  beat_t sb[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  logic        held;
  logic [55:0] h_data;
  logic [1:0]  h_lane;
  logic        h_last, h_sat;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string nm);
    n_cmp++;
    n_bad++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  function automatic logic [55:0] model(input longint v, output logic s);
    longint r;
    r = v;
    s = 1'b0;
`ifdef MAC_DRAIN_SAT_EN
    if (v > 32767) begin r = 32767; s = 1'b1; end
    else if (v < -32768) begin r = -32768; s = 1'b1; end
`endif
    return r[55:0];
  endfunction

  task automatic push_word(input vec_t v);
    longint l[4];
    beat_t  b;
    logic   s;
    l[0] = v.l0; l[1] = v.l1; l[2] = v.l2; l[3] = v.l3;
    for (int k = 0; k < v.nb; k++) begin
      b.data = model(l[k], s);
      b.sat  = s;
      b.lane = k[1:0];
      b.last = (k == v.nb - 1);
      sb.push_back(b);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accept edge.
  task automatic send_word(input vec_t v);
    int t;
    in_valid = 1'b1;
    in_data  = v.data;
    in_level = v.level;
    t = 0;
    while (!in_ready && t < 200) begin
      @(posedge clk); #1;
      t++;
    end
    if (!in_ready) fail_now("in_ready_timeout");
    if (v.level != 2'b11) push_word(v);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = $urandom();
    in_level = 2'($urandom_range(0, 3));
  endtask

  task automatic wait_drain(input bit rnd);
    int t;
    t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(posedge clk); #1;
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      t++;
    end
    out_ready = 1'b1;
    chk("drain_empty", 64'(sb.size()), 64'd0);
    @(posedge clk); #1;
  endtask

  // Monitor: compare completed beats against the scoreboard, and check that
  // a stalled beat holds its values.
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      held = 1'b0;
    end else begin
      if (held && out_valid) begin
        chk("stall_data", 64'(out_data), 64'(h_data));
        chk("stall_lane", 64'(out_lane), 64'(h_lane));
        chk("stall_last", 64'(out_last), 64'(h_last));
        chk("stall_sat",  64'(out_sat),  64'(h_sat));
      end
      held   = out_valid && !out_ready;
      h_data = out_data;
      h_lane = out_lane;
      h_last = out_last;
      h_sat  = out_sat;
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          fail_now("unexpected_beat");
        end else begin
          e = sb.pop_front();
          chk("beat_data", 64'(out_data), 64'(e.data));
          chk("beat_lane", 64'(out_lane), 64'(e.lane));
          chk("beat_last", 64'(out_last), 64'(e.last));
          chk("beat_sat",  64'(out_sat),  64'(e.sat));
        end
      end
    end
  end

  initial begin
    vec_t  w;
    logic  s;
    int    t;
    int    stale;

    vecs[0] = '{2'b10, {14'h3FFF, 14'h0001, 14'h2000, 14'h1FFF}, 4, 8191, -8192, 1, -1};
    vecs[1] = '{2'b01, {28'h8000000, 28'h0000005}, 2, 5, -134217728, 0, 0};
    vecs[2] = '{2'b00, 56'd65536, 1, 65536, 0, 0, 0};
    vecs[3] = '{2'b00, -56'sd32768, 1, -32768, 0, 0, 0};
    vecs[4] = '{2'b01, {28'h7FFFFFF, 28'hFFF8000}, 2, -32768, 134217727, 0, 0};
    vecs[5] = '{2'b10, {14'h2001, 14'h0000, 14'h1000, 14'h3FFE}, 4, -2, 4096, 0, -8191};
    vecs[6] = '{2'b00, 56'h7F_FFFF_FFFF_FFFF, 1, 64'sh007F_FFFF_FFFF_FFFF, 0, 0, 0};
    vecs[7] = '{2'b00, -56'sd40000, 1, -40000, 0, 0, 0};

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_level  = '0;
    out_ready = 1'b1;
    held      = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    chk("rst_out_data",  64'(out_data),  64'd0);
    chk("rst_err",       64'(err_level), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Table: every vector with free-running consumer, then with random stalls.
    for (int i = 0; i < 8; i++) begin
      send_word(vecs[i]);
      chk("lat1_valid", 64'(out_valid), 64'd1);
      wait_drain(1'b0);
    end
    for (int i = 0; i < 8; i++) begin
      send_word(vecs[i]);
      wait_drain(1'b1);
    end

    // Level 01 with three stalled cycles on lane 0.
    out_ready = 1'b0;
    send_word(vecs[1]);
    for (int c = 0; c < 3; c++) begin
      chk("bp_lane0_data", 64'(out_data), 64'd5);
      chk("bp_lane0_idx",  64'(out_lane), 64'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    w = vecs[1];
    chk("bp_lane1_data", 64'(out_data), 64'(model(w.l1, s)));
    chk("bp_lane1_last", 64'(out_last), 64'd1);
    wait_drain(1'b0);

    // Back-to-back: level-00 word offered during the last beat of a level-10 word.
    send_word(vecs[0]);
    t = 0;
    while (!(out_valid && out_last) && t < 20) begin
      @(posedge clk); #1;
      t++;
    end
    chk("b2b_reach_last", 64'(out_valid && out_last), 64'd1);
    chk("b2b_in_ready",   64'(in_ready), 64'd1);
    w = '{2'b00, 56'd7, 1, 7, 0, 0, 0};
    in_valid = 1'b1;
    in_data  = w.data;
    in_level = w.level;
    push_word(w);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b_valid", 64'(out_valid), 64'd1);
    chk("b2b_data",  64'(out_data),  64'd7);
    chk("b2b_last",  64'(out_last),  64'd1);
    wait_drain(1'b0);

    // Reserved level: consumed, no beat, sticky error.
    in_valid = 1'b1;
    in_level = 2'b11;
    in_data  = 56'h123;
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk("rsv_no_valid", 64'(out_valid), 64'd0);
      chk("rsv_err",      64'(err_level), 64'd1);
      @(posedge clk); #1;
    end
    send_word(vecs[2]);
    wait_drain(1'b0);
    chk("rsv_err_sticky", 64'(err_level), 64'd1);

    // Reset in the middle of a stalled drain.
    out_ready = 1'b0;
    send_word(vecs[0]);
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    chk("mid_rst_valid", 64'(out_valid), 64'd0);
    chk("mid_rst_ready", 64'(in_ready),  64'd1);
    chk("mid_rst_err",   64'(err_level), 64'd0);
    chk("mid_rst_data",  64'(out_data),  64'd0);
    chk("mid_rst_last",  64'(out_last),  64'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    stale = 0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    chk("no_stale_beats", 64'(stale), 64'd0);

    // One more word after reset drains cleanly.
    send_word(vecs[7]);
    wait_drain(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
